// File: rtl/mips_pkg.sv
// Shared definitions for the 32-bit single-cycle MIPS datapath.
// Widths, special register indices and the ALU control encodings.
package mips_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_WIDTH-1:0] REG_RA   = 5'd31;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] ridx_t;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_XOR = 3'b010,
    ALU_NOR = 3'b011,
    ALU_SLT = 3'b100,
    ALU_ADD = 3'b101,
    ALU_SUB = 3'b110
  } alu_ctr_e;

  // Writeback bundle handed to the register file.
  typedef struct packed {
    logic  we;
    ridx_t idx;
    word_t data;
  } wb_t;

  function automatic word_t alu_eval(
    input alu_ctr_e op,
    input word_t    a,
    input word_t    b
  );
    word_t r;
    r = '0;
    case (op)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_NOR: r = ~(a | b);
      ALU_SLT: r = {31'd0, $signed(a) < $signed(b)};
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic alu_zero(input word_t r);
    return r == '0;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: index-0 force, write bypass, storage mux.
// Ports: rst_n, idx, regs (flattened storage), we/wr_idx/wr_data, rdata.
module regfile_read_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS_EN  = 1
) (
  input  logic                                   rst_n,
  input  logic [ADDR_WIDTH-1:0]                  idx,
  input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] regs,
  input  logic                                   we,
  input  logic [ADDR_WIDTH-1:0]                  wr_idx,
  input  logic [DATA_WIDTH-1:0]                  wr_data,
  output logic [DATA_WIDTH-1:0]                  rdata
);

  logic is_zero;
  logic hit;

  assign is_zero = (idx == '0);

  // No forwarding while reset is asserted: that write is dropped.
  assign hit = (BYPASS_EN != 0)
             && rst_n
             && we
             && (wr_idx != '0)
             && (wr_idx == idx);

  always_comb begin
    rdata = regs[idx];
    unique case (1'b1)
      is_zero: rdata = '0;
      hit:     rdata = wr_data;
      default: rdata = regs[idx];
    endcase
  end

endmodule

// File: rtl/register_file_32.sv
// 32 x 32 MIPS register file, $zero hardwired, two async read ports.
// Ports: clk, rst_n, read_reg1/2, write_reg, write_data, reg_write, read_data1/2.
module register_file_32 #(
  parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = mips_pkg::ADDR_WIDTH,
  parameter int BYPASS_EN  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  import mips_pkg::*;

  localparam int NREGS = 2 ** ADDR_WIDTH;

  // Register 0 has no storage.
  logic [DATA_WIDTH-1:0] mem [1:NREGS-1];

  logic [NREGS-1:0][DATA_WIDTH-1:0] stored;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (reg_write && (write_reg != '0)) begin
      mem[write_reg] <= write_data;
    end
  end

  always_comb begin
    stored = '0;
    for (int i = 1; i < NREGS; i++) begin
      stored[i] = mem[i];
    end
  end

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS_EN  (BYPASS_EN)
  ) u_rp1 (
    .rst_n   (rst_n),
    .idx     (read_reg1),
    .regs    (stored),
    .we      (reg_write),
    .wr_idx  (write_reg),
    .wr_data (write_data),
    .rdata   (read_data1)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS_EN  (BYPASS_EN)
  ) u_rp2 (
    .rst_n   (rst_n),
    .idx     (read_reg2),
    .regs    (stored),
    .we      (reg_write),
    .wr_idx  (write_reg),
    .wr_data (write_data),
    .rdata   (read_data2)
  );

endmodule

// File: tb/tb_register_file_32.sv
// Directed bench for register_file_32, bypass on and off side by side.
// Inputs change on the falling edge; outputs sampled before the next rise.
module tb_register_file_32;

  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] rd1b, rd2b;
  logic [31:0] rd1n, rd2n;

  int total = 0;
  int bad   = 0;

  register_file_32 #(.BYPASS_EN(1)) u_byp (
    .clk        (clk),
    .rst_n      (rst_n),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reg_write  (reg_write),
    .read_data1 (rd1b),
    .read_data2 (rd2b)
  );

  register_file_32 #(.BYPASS_EN(0)) u_nob (
    .clk        (clk),
    .rst_n      (rst_n),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reg_write  (reg_write),
    .read_data1 (rd1n),
    .read_data2 (rd2n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_write  = 1'b1;
    write_reg  = a;
    write_data = d;
    @(posedge clk);
    #1;
    reg_write  = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    read_reg1 = a1;
    read_reg2 = a2;
    #1;
  endtask

  task automatic test_reset;
    wr(5'd5, 32'hDEADBEEF);
    rd(5'd5, 5'd5);
    total++;
    if (rd1b !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL pre_reset_r5 got=%h exp=%h", rd1b, 32'hDEADBEEF);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd(5'd5, 5'd31);
    total++;
    if (rd1b !== 32'h0 || rd2b !== 32'h0 || rd1n !== 32'h0 || rd2n !== 32'h0) begin
      bad++;
      $display("FAIL reset_r5_r31 got=%h %h %h %h exp=0", rd1b, rd2b, rd1n, rd2n);
    end
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      total++;
      if (rd1b !== 32'h0 || rd2b !== 32'h0) begin
        bad++;
        $display("FAIL reset_all idx=%0d got=%h %h exp=0", i, rd1b, rd2b);
      end
    end
  endtask

  task automatic test_write_alu;
    logic [31:0] res;
    wr(5'd1, 32'hAAAAAAAA);
    wr(5'd2, 32'h55555555);
    rd(5'd1, 5'd2);
    total++;
    if (rd1b !== 32'hAAAAAAAA || rd1n !== 32'hAAAAAAAA) begin
      bad++;
      $display("FAIL wr_r1 got=%h %h exp=aaaaaaaa", rd1b, rd1n);
    end
    total++;
    if (rd2b !== 32'h55555555 || rd2n !== 32'h55555555) begin
      bad++;
      $display("FAIL wr_r2 got=%h %h exp=55555555", rd2b, rd2n);
    end
    res = alu_eval(ALU_AND, rd1b, rd2b);
    total++;
    if (res !== 32'h0 || alu_zero(res) !== 1'b1) begin
      bad++;
      $display("FAIL alu_and got=%h zero=%b exp=0 zero=1", res, alu_zero(res));
    end
  endtask

  task automatic test_zero;
    wr(5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd0);
    total++;
    if (rd1b !== 32'h0 || rd2b !== 32'h0 || rd1n !== 32'h0 || rd2n !== 32'h0) begin
      bad++;
      $display("FAIL r0_after_write got=%h %h %h %h exp=0", rd1b, rd2b, rd1n, rd2n);
    end
    @(negedge clk);
    reg_write  = 1'b1;
    write_reg  = 5'd0;
    write_data = 32'hFFFFFFFF;
    rd(5'd0, 5'd0);
    total++;
    if (rd1b !== 32'h0 || rd2b !== 32'h0) begin
      bad++;
      $display("FAIL r0_bypass got=%h %h exp=0", rd1b, rd2b);
    end
    @(posedge clk);
    #1;
    reg_write = 1'b0;
  endtask

  task automatic test_write_disable;
    @(negedge clk);
    reg_write  = 1'b0;
    write_reg  = 5'd1;
    write_data = 32'h0BADF00D;
    rd(5'd1, 5'd1);
    total++;
    if (rd1b !== 32'hAAAAAAAA) begin
      bad++;
      $display("FAIL we0_no_bypass got=%h exp=aaaaaaaa", rd1b);
    end
    @(posedge clk);
    #1;
    total++;
    if (rd1b !== 32'hAAAAAAAA || rd2n !== 32'hAAAAAAAA) begin
      bad++;
      $display("FAIL we0_no_write got=%h %h exp=aaaaaaaa", rd1b, rd2n);
    end
  endtask

  task automatic test_bypass;
    wr(5'd3, 32'h0000FFFF);
    @(negedge clk);
    reg_write  = 1'b1;
    write_reg  = 5'd3;
    write_data = 32'hFFFF0000;
    rd(5'd3, 5'd3);
    total++;
    if (rd1b !== 32'hFFFF0000 || rd2b !== 32'hFFFF0000) begin
      bad++;
      $display("FAIL bypass_on got=%h %h exp=ffff0000", rd1b, rd2b);
    end
    total++;
    if (rd1n !== 32'h0000FFFF || rd2n !== 32'h0000FFFF) begin
      bad++;
      $display("FAIL bypass_off_pre got=%h %h exp=0000ffff", rd1n, rd2n);
    end
    rd(5'd3, 5'd1);
    total++;
    if (rd1b !== 32'hFFFF0000 || rd2b !== 32'hAAAAAAAA) begin
      bad++;
      $display("FAIL bypass_one_port got=%h %h exp=ffff0000 aaaaaaaa", rd1b, rd2b);
    end
    rd(5'd3, 5'd3);
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    #1;
    total++;
    if (rd1n !== 32'hFFFF0000 || rd2n !== 32'hFFFF0000 || rd1b !== 32'hFFFF0000) begin
      bad++;
      $display("FAIL bypass_post got=%h %h %h exp=ffff0000", rd1n, rd2n, rd1b);
    end
  endtask

  task automatic test_collision;
    wr(5'd7, 32'hCAFEF00D);
    @(negedge clk);
    rst_n      = 1'b0;
    reg_write  = 1'b1;
    write_reg  = 5'd7;
    write_data = 32'h12345678;
    rd(5'd7, 5'd7);
    total++;
    if (rd1b !== 32'hCAFEF00D || rd2b !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL no_bypass_in_reset got=%h %h exp=cafef00d", rd1b, rd2b);
    end
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    reg_write = 1'b0;
    #1;
    total++;
    if (rd1b !== 32'h0 || rd1n !== 32'h0) begin
      bad++;
      $display("FAIL collision_r7 got=%h %h exp=0", rd1b, rd1n);
    end
    rd(5'd1, 5'd3);
    total++;
    if (rd1b !== 32'h0 || rd2b !== 32'h0) begin
      bad++;
      $display("FAIL collision_clear got=%h %h exp=0", rd1b, rd2b);
    end
    wr(5'd7, 32'h12345678);
    rd(5'd7, 5'd7);
    total++;
    if (rd1b !== 32'h12345678 || rd2n !== 32'h12345678) begin
      bad++;
      $display("FAIL resume_write got=%h %h exp=12345678", rd1b, rd2n);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] e1, e2;
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), i * 32'h01010101);
    end
    for (int i = 0; i < 32; i++) begin
      e1 = i * 32'h01010101;
      e2 = (31 - i) * 32'h01010101;
      rd(5'(i), 5'(31 - i));
      total++;
      if (rd1b !== e1 || rd2b !== e2 || rd1n !== e1 || rd2n !== e2) begin
        bad++;
        $display("FAIL sweep i=%0d got=%h %h %h %h exp=%h %h",
                 i, rd1b, rd2b, rd1n, rd2n, e1, e2);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b1;
    read_reg1  = '0;
    read_reg2  = '0;
    write_reg  = '0;
    write_data = '0;
    reg_write  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    test_reset;
    test_write_alu;
    test_zero;
    test_write_disable;
    test_bypass;
    test_collision;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_file_32.md
Name: register_file_32

Overview:
- Architectural register file for the 32-bit single-cycle MIPS datapath.
- Sits directly upstream of the 32-bit ALU and drives its two source operands (alu_src1 from read_data1; alu_src2 via the immediate mux from read_data2).
- Accepts the writeback result (ALU result or memory data) on one synchronous write port.
- Provides 32 x 32-bit registers with $zero hardwired, two combinational read ports and an optional same-cycle write-to-read bypass.

Parameters:
- DATA_WIDTH, 32, register and port data width.
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH.
- BYPASS_EN, 1, 1 = a read of the register being written this cycle returns write_data; 0 = returns the old stored value.

Ports:
- clk  input  1  Datapath clock; all state updates on the rising edge.
- rst_n  input  1  Synchronous, active-low reset, sampled on the rising edge of clk.
- read_reg1  input  ADDR_WIDTH  Index for read port 1 (rs).
- read_reg2  input  ADDR_WIDTH  Index for read port 2 (rt).
- write_reg  input  ADDR_WIDTH  Index for the write port (rd/rt, selected upstream).
- write_data  input  DATA_WIDTH  Writeback value.
- reg_write  input  1  Write enable.
- read_data1  output  DATA_WIDTH  Contents of read_reg1; feeds alu_src1.
- read_data2  output  DATA_WIDTH  Contents of read_reg2; feeds the alu_src2 mux.

Behaviour:
- Storage: NUM_REGS registers of DATA_WIDTH. Register 0 is never stored and always reads 32'h0.
- Reset: one clock. On a rising edge with rst_n=0, all registers 1..31 clear to 0. Reset has priority over a simultaneous write, and that write is lost. After reset, both outputs read 0 for every index.
- Reset mid-operation: asserting rst_n during a stream of writes discards the write on the reset edge. Writes resume on the first edge with rst_n=1.
- Write: on a rising edge with rst_n=1, reg_write=1 and write_reg!=0, reg[write_reg] <= write_data. With reg_write=1 and write_reg=0 there is no state change.
- Write latency: the value is visible through the stored path from the cycle after the edge.
- Read: purely combinational from the read_reg inputs, with zero-cycle latency, so a single-cycle instruction reads operands in the same cycle they are addressed.
- Both ports may address the same register; each returns identical data.
- Bypass (BYPASS_EN=1): for each port independently, if reg_write=1, write_reg!=0 and write_reg==read_regN, then read_dataN = write_data. Otherwise read_dataN = stored value.
  - Bypass is gated by rst_n: with rst_n=0, no bypass occurs and reads return stored values.
- Bypass disabled (BYPASS_EN=0): reads always return the stored value (pre-edge old value).
- Index 0 override: read_regN==0 forces read_dataN=0 regardless of the bypass condition.
- X on read_reg inputs may propagate X to that port only; the other port and the stored state are unaffected.
- No other outputs, flags or status. Operand signedness is the ALU's concern; this block is width-transparent.

Decomposition:
- Shared package mips_pkg:
  - DATA_WIDTH=32, ADDR_WIDTH=5, NUM_REGS=32.
  - REG_ZERO=5'd0, REG_RA=5'd31.
  - The ALU control encodings (AND 000, OR 001, XOR 010, NOR 011, SLT 100, ADD 101, SUB 110), so datapath-level benches share one source.
- One natural sub-module: regfile_read_port (index-0 force, bypass compare and storage mux), instantiated twice.
- The storage array and write logic stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 1 edge after writing 32'hDEADBEEF to r5. Release, then read r5 and r31 -> both 32'h00000000.
- Write/readback feeding the ALU:
  - Write r1=32'hAAAAAAAA and r2=32'h55555555 on consecutive edges.
  - Set read_reg1=1 and read_reg2=2 -> read_data1=32'hAAAAAAAA, read_data2=32'h55555555.
  - With the ALU attached and alu_ctr=000 -> result 0 and zero_bit=1.
- $zero: write r0=32'hFFFFFFFF, then read r0 on both ports -> 0. Also read r0 while reg_write=1, write_reg=0 (bypass condition) -> 0.
- Bypass:
  - r3 holds 32'h0000FFFF.
  - In the same cycle set reg_write=1, write_reg=3, write_data=32'hFFFF0000, read_reg1=3, read_reg2=3.
  - BYPASS_EN=1 -> both ports show 32'hFFFF0000 before the edge.
  - BYPASS_EN=0 -> both ports show 32'h0000FFFF before the edge and 32'hFFFF0000 after.
- Reset vs write collision: on one edge set rst_n=0, reg_write=1, write_reg=7, write_data=32'h12345678 -> r7 reads 0 afterwards. No bypass is visible while rst_n=0.
- Sweep: write r[i]=i*32'h01010101 for i=1..31, then read all pairs (i, 31-i) -> expected values match on both ports, and r0=0.
